except_commit: RTL and testbench
================================

Name: except_commit

Overview:
- WB-stage exception/interrupt commit unit; the producer side of the CP0 exception interface.
- Holds the WB instruction and arbitrates its exception, ERET and pending interrupt.
- Drives CP0 update strobes: wb_except, wb_excode, wb_bd, eret_flush, mtc0_we, c0_addr.
- Runs a flush handshake that redirects fetch to the exception vector or to EPC.

Parameters:
EXC_VECTOR, 32'hbfc00380, exception entry PC (BEV=1)
C0_ADDR_W, 8, CP0 register address width ({rd,sel})

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ms_to_ws_valid  in  1  MEM presents instruction
ws_allowin  out  1  WB can accept
ms_pc  in  32  instruction PC
ms_bd  in  1  instruction is in a delay slot
ms_ex  in  1  earlier-stage exception flag
ms_excode  in  5  earlier-stage excode
ms_eret  in  1  instruction is ERET
ms_mtc0  in  1  instruction is MTC0
ms_c0_addr  in  C0_ADDR_W  MTC0 target
c0_status_ie  in  1  CP0 Status.IE
c0_status_exl  in  1  CP0 Status.EXL
c0_status_im  in  8  CP0 Status.IM
c0_cause_ip  in  8  CP0 Cause.IP
c0_epc  in  32  CP0 EPC
wb_except  out  1  exception commit strobe
wb_bd  out  1  BD of the excepting instruction
wb_excode  out  5  committed excode
wb_pc  out  32  PC for EPC
eret_flush  out  1  ERET commit strobe
mtc0_we  out  1  CP0 write strobe
c0_addr  out  C0_ADDR_W  CP0 write address
flush_req  out  1  redirect request to fetch
flush_pc  out  32  redirect target
fs_flush_ack  in  1  fetch accepted the redirect

Behaviour:
- Reset (async, resetn=0): state=RUN; ws_valid=0; flush_req=0; flush_pc=0; all strobes 0.
- WB register:
  - Loads on ms_to_ws_valid & ws_allowin.
  - ws_allowin = ~ws_valid | (state==RUN).
  - ws_valid clears when WB empties.
- States:
  - RUN: normal operation.
  - FLUSH: flush_req=1, flush_pc held stable.
- Commit cycle: ws_valid & state==RUN.
- int_take = c0_status_ie & ~c0_status_exl & |(c0_status_im & c0_cause_ip), sampled in the commit cycle.
- Commit priority:
  - int_take: wb_except=1, excode 5'h00.
  - else ws_ex: wb_except=1, excode=ws_excode.
  - else ws_eret: eret_flush=1.
- wb_except and eret_flush:
  - Combinational, single-cycle, mutually exclusive.
  - wb_bd=ws_bd and wb_pc=ws_pc are valid while wb_except=1.
- mtc0_we = commit & ws_mtc0 & ~wb_except; c0_addr = ws_c0_addr.
- On wb_except or eret_flush:
  - Go to FLUSH next cycle.
  - flush_pc latched as EXC_VECTOR (exception) or c0_epc sampled in the commit cycle (ERET).
  - The WB instruction is retired (ws_valid cleared).
- FLUSH:
  - flush_req held until a cycle with fs_flush_ack=1; then return to RUN next cycle.
  - While in FLUSH, ms_to_ws_valid is accepted and discarded (ws_valid stays 0).
  - No strobes are generated.
- Simultaneous events:
  - Interrupt on an ERET/MTC0/excepting instruction: interrupt wins; ERET and MTC0 are suppressed.
  - fs_flush_ack while in RUN is ignored.
  - Interrupt arriving during FLUSH is not taken until the next commit in RUN.
- Reset mid-FLUSH: immediate return to RUN; flush_req drops asynchronously.

Optional Feature:
- Macro: EXCEPT_COMMIT_BADVADDR_EN.
- Defined:
  - Adds input ms_badvaddr[31:0], carried through the WB register.
  - Adds outputs wb_badvaddr[31:0] and wb_badvaddr_we.
  - wb_badvaddr_we = wb_except & (wb_excode==5'h04 | wb_excode==5'h05); it is 0 for interrupts.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: resetn=0 mid-FLUSH -> flush_req=0 and ws_allowin=1 immediately; state RUN after release.
- Syscall: ms_ex=1, excode 5'h08, bd=1, pc=32'hbfc00100 -> one-cycle wb_except with excode 08, wb_bd=1, wb_pc=bfc00100.
  - Next cycle flush_req=1, flush_pc=bfc00380, held until ack; RUN the cycle after ack.
- ERET: c0_epc=32'hbfc00200 -> one-cycle eret_flush, wb_except=0; flush_pc=bfc00200.
- Interrupt over MTC0: ie=1, exl=0, im=8'h80, ip=8'h80, instruction is MTC0 -> wb_except with excode 00, mtc0_we=0.
  - Repeat with exl=1 -> no exception, mtc0_we=1.
- Flush drain: during a 3-cycle FLUSH, present 3 valid instructions -> all accepted with ws_allowin=1; no strobes; ws_valid stays 0.
- Badvaddr (EXCEPT_COMMIT_BADVADDR_EN defined):
  - AdEL with badvaddr 32'h00000003 -> wb_badvaddr_we=1, wb_badvaddr=00000003.
  - Interrupt commit -> wb_badvaddr_we=0.

Source files
------------

// File: rtl/except_commit.sv
// WB-stage commit unit: arbitrates exception, ERET and interrupt, strobes CP0 and redirects fetch.
// Optional macro EXCEPT_COMMIT_BADVADDR_EN adds the BadVAddr path through the WB register.
module except_commit #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
    parameter int unsigned C0_ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ms_to_ws_valid,
    output logic                 ws_allowin,
    input  logic [31:0]          ms_pc,
    input  logic                 ms_bd,
    input  logic                 ms_ex,
    input  logic [4:0]           ms_excode,
    input  logic                 ms_eret,
    input  logic                 ms_mtc0,
    input  logic [C0_ADDR_W-1:0] ms_c0_addr,
`ifdef EXCEPT_COMMIT_BADVADDR_EN
    input  logic [31:0]          ms_badvaddr,
    output logic [31:0]          wb_badvaddr,
    output logic                 wb_badvaddr_we,
`endif
    input  logic                 c0_status_ie,
    input  logic                 c0_status_exl,
    input  logic [7:0]           c0_status_im,
    input  logic [7:0]           c0_cause_ip,
    input  logic [31:0]          c0_epc,
    output logic                 wb_except,
    output logic                 wb_bd,
    output logic [4:0]           wb_excode,
    output logic [31:0]          wb_pc,
    output logic                 eret_flush,
    output logic                 mtc0_we,
    output logic [C0_ADDR_W-1:0] c0_addr,
    output logic                 flush_req,
    output logic [31:0]          flush_pc,
    input  logic                 fs_flush_ack
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e                 state_q;
    logic                   ws_valid_q;
    logic [31:0]            ws_pc_q;
    logic                   ws_bd_q;
    logic                   ws_ex_q;
    logic [4:0]             ws_excode_q;
    logic                   ws_eret_q;
    logic                   ws_mtc0_q;
    logic [C0_ADDR_W-1:0]   ws_c0_addr_q;
    logic [31:0]            flush_pc_q;
`ifdef EXCEPT_COMMIT_BADVADDR_EN
    logic [31:0]            ws_badvaddr_q;
`endif

    logic commit_c;
    logic int_take_c;
    logic flush_go_c;
    logic ws_load_c;

    // Commit arbitration: interrupt > earlier-stage exception > ERET; MTC0 dies under any exception.
    always_comb begin
        commit_c   = ws_valid_q & (state_q == RUN);
        int_take_c = c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip));
        wb_except  = commit_c & (int_take_c | ws_ex_q);
        wb_excode  = int_take_c ? 5'h00 : ws_excode_q;
        eret_flush = commit_c & ~wb_except & ws_eret_q;
        mtc0_we    = commit_c & ws_mtc0_q & ~wb_except;
        flush_go_c = wb_except | eret_flush;
    end

    assign ws_allowin = ~ws_valid_q | (state_q == RUN);
    assign ws_load_c  = ms_to_ws_valid & ws_allowin;
    assign wb_bd      = ws_bd_q;
    assign wb_pc      = ws_pc_q;
    assign c0_addr    = ws_c0_addr_q;
    assign flush_req  = (state_q == FLUSH);
    assign flush_pc   = flush_pc_q;

`ifdef EXCEPT_COMMIT_BADVADDR_EN
    assign wb_badvaddr    = ws_badvaddr_q;
    assign wb_badvaddr_we = wb_except & ((wb_excode == 5'h04) | (wb_excode == 5'h05));
`endif

    // Flush FSM; an instruction arriving alongside or during a flush is younger and is discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RUN;
            ws_valid_q <= 1'b0;
            flush_pc_q <= 32'h0;
        end else begin
            case (state_q)
                RUN: begin
                    if (flush_go_c) begin
                        state_q    <= FLUSH;
                        ws_valid_q <= 1'b0;
                        flush_pc_q <= wb_except ? EXC_VECTOR : c0_epc;
                    end else begin
                        ws_valid_q <= ws_load_c;
                    end
                end
                FLUSH: begin
                    ws_valid_q <= 1'b0;
                    if (fs_flush_ack) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    ws_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // WB payload register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_pc_q      <= 32'h0;
            ws_bd_q      <= 1'b0;
            ws_ex_q      <= 1'b0;
            ws_excode_q  <= 5'h00;
            ws_eret_q    <= 1'b0;
            ws_mtc0_q    <= 1'b0;
            ws_c0_addr_q <= '0;
`ifdef EXCEPT_COMMIT_BADVADDR_EN
            ws_badvaddr_q <= 32'h0;
`endif
        end else if (ws_load_c) begin
            ws_pc_q      <= ms_pc;
            ws_bd_q      <= ms_bd;
            ws_ex_q      <= ms_ex;
            ws_excode_q  <= ms_excode;
            ws_eret_q    <= ms_eret;
            ws_mtc0_q    <= ms_mtc0;
            ws_c0_addr_q <= ms_c0_addr;
`ifdef EXCEPT_COMMIT_BADVADDR_EN
            ws_badvaddr_q <= ms_badvaddr;
`endif
        end
    end

endmodule

// File: tb/tb_except_commit.sv
// Self-checking bench for except_commit: directed table, corner sequences and a random run against a model.
module tb_except_commit;

    localparam int unsigned AW     = 8;
    localparam logic [31:0] EXC_PC = 32'hbfc00380;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ms_to_ws_valid;
    logic          ws_allowin;
    logic [31:0]   ms_pc;
    logic          ms_bd;
    logic          ms_ex;
    logic [4:0]    ms_excode;
    logic          ms_eret;
    logic          ms_mtc0;
    logic [AW-1:0] ms_c0_addr;
    logic [31:0]   ms_badvaddr;
    logic          c0_status_ie;
    logic          c0_status_exl;
    logic [7:0]    c0_status_im;
    logic [7:0]    c0_cause_ip;
    logic [31:0]   c0_epc;
    logic          wb_except;
    logic          wb_bd;
    logic [4:0]    wb_excode;
    logic [31:0]   wb_pc;
    logic          eret_flush;
    logic          mtc0_we;
    logic [AW-1:0] c0_addr;
    logic          flush_req;
    logic [31:0]   flush_pc;
    logic          fs_flush_ack;
`ifdef EXCEPT_COMMIT_BADVADDR_EN
    logic [31:0]   wb_badvaddr;
    logic          wb_badvaddr_we;
`endif

    always #5 clk = ~clk;

    except_commit #(.EXC_VECTOR(EXC_PC), .C0_ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex), .ms_excode(ms_excode),
        .ms_eret(ms_eret), .ms_mtc0(ms_mtc0), .ms_c0_addr(ms_c0_addr),
`ifdef EXCEPT_COMMIT_BADVADDR_EN
        .ms_badvaddr(ms_badvaddr), .wb_badvaddr(wb_badvaddr), .wb_badvaddr_we(wb_badvaddr_we),
`endif
        .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
        .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
        .wb_except(wb_except), .wb_bd(wb_bd), .wb_excode(wb_excode), .wb_pc(wb_pc),
        .eret_flush(eret_flush), .mtc0_we(mtc0_we), .c0_addr(c0_addr),
        .flush_req(flush_req), .flush_pc(flush_pc), .fs_flush_ack(fs_flush_ack)
    );

    typedef struct packed {
        logic          ex;
        logic [4:0]    excode;
        logic          bd;
        logic [31:0]   pc;
        logic          eret;
        logic          mtc0;
        logic [AW-1:0] addr;
        logic [31:0]   bva;
    } instr_t;

    // Reference model: at most one instruction sits in WB; a flush is a flag plus target.
    instr_t      m_q[$];
    bit          m_flush;
    logic [31:0] m_fpc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_flush = 1'b0;
        m_fpc   = 32'h0;
    endtask

    task automatic idle_inputs();
        ms_to_ws_valid = 1'b0; ms_pc = 32'h0; ms_bd = 1'b0; ms_ex = 1'b0; ms_excode = 5'h00;
        ms_eret = 1'b0; ms_mtc0 = 1'b0; ms_c0_addr = '0; ms_badvaddr = 32'h0;
        c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = 8'h00; c0_cause_ip = 8'h00;
        c0_epc = 32'h0; fs_flush_ack = 1'b0;
    endtask

    // One clock: inputs already set just after a negedge; check vs model, advance model, go to next negedge.
    task automatic cycle();
        bit commit, irq, e_exc, e_eret, e_mtc0, e_bw;
        logic [4:0] e_code;
        instr_t w, nw;
        #1;
        commit = (m_q.size() != 0) && !m_flush;
        w      = commit ? m_q[0] : '0;
        irq    = c0_status_ie && !c0_status_exl && ((c0_status_im & c0_cause_ip) != 8'h00);
        e_exc  = commit && (irq || w.ex);
        e_code = irq ? 5'h00 : w.excode;
        e_eret = commit && !e_exc && w.eret;
        e_mtc0 = commit && !e_exc && w.mtc0;
        e_bw   = e_exc && (e_code == 5'h04 || e_code == 5'h05);
        chk("ws_allowin", 32'(ws_allowin), 32'(m_q.size() == 0 || !m_flush));
        chk("wb_except",  32'(wb_except),  32'(e_exc));
        chk("eret_flush", 32'(eret_flush), 32'(e_eret));
        chk("mtc0_we",    32'(mtc0_we),    32'(e_mtc0));
        chk("flush_req",  32'(flush_req),  32'(m_flush));
        chk("flush_pc",   flush_pc,        m_fpc);
        if (e_exc) begin
            chk("wb_excode", 32'(wb_excode), 32'(e_code));
            chk("wb_bd",     32'(wb_bd),     32'(w.bd));
            chk("wb_pc",     wb_pc,          w.pc);
        end
        if (e_mtc0) chk("c0_addr", 32'(c0_addr), 32'(w.addr));
`ifdef EXCEPT_COMMIT_BADVADDR_EN
        chk("wb_badvaddr_we", 32'(wb_badvaddr_we), 32'(e_bw));
        if (e_bw) chk("wb_badvaddr", wb_badvaddr, w.bva);
`endif
        nw = '{ex: ms_ex, excode: ms_excode, bd: ms_bd, pc: ms_pc, eret: ms_eret,
               mtc0: ms_mtc0, addr: ms_c0_addr, bva: ms_badvaddr};
        if (m_flush) begin
            if (fs_flush_ack) m_flush = 1'b0;
        end else begin
            m_q.delete();
            if (e_exc || e_eret) begin
                m_flush = 1'b1;
                m_fpc   = e_exc ? EXC_PC : c0_epc;
            end else if (ms_to_ws_valid) begin
                m_q.push_back(nw);
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        string         name;
        logic          ex;
        logic [4:0]    code;
        logic          bd;
        logic [31:0]   pc;
        logic          eret;
        logic          mtc0;
        logic [AW-1:0] addr;
        logic [31:0]   bva;
        logic          ie;
        logic          exl;
        logic [7:0]    im;
        logic [7:0]    ip;
        logic [31:0]   epc;
        logic          x_exc;
        logic [4:0]    x_code;
        logic          x_eret;
        logic          x_mtc0;
        logic [31:0]   x_fpc;
        logic          x_bw;
    } vec_t;

    localparam int NT = 8;
    vec_t tbl[NT];

    initial begin
        //           name       ex code   bd pc            eret mtc0 addr   bva           ie exl im     ip     epc           exc code   eret mtc0 fpc           bw
        tbl[0] = '{"syscall",   1, 5'h08, 1, 32'hbfc00100, 0,   0,   8'h00, 32'h0,        0, 0,  8'h00, 8'h00, 32'h0,        1,  5'h08, 0,   0,   32'hbfc00380, 0};
        tbl[1] = '{"eret",      0, 5'h00, 0, 32'hbfc00040, 1,   0,   8'h00, 32'h0,        0, 0,  8'h00, 8'h00, 32'hbfc00200, 0,  5'h00, 1,   0,   32'hbfc00200, 0};
        tbl[2] = '{"int_mtc0",  0, 5'h00, 0, 32'hbfc00300, 0,   1,   8'h60, 32'h0,        1, 0,  8'h80, 8'h80, 32'h0,        1,  5'h00, 0,   0,   32'hbfc00380, 0};
        tbl[3] = '{"exl_mtc0",  0, 5'h00, 0, 32'hbfc00304, 0,   1,   8'h60, 32'h0,        1, 1,  8'h80, 8'h80, 32'h0,        0,  5'h00, 0,   1,   32'h0,        0};
        tbl[4] = '{"int_eret",  0, 5'h00, 1, 32'hbfc00400, 1,   0,   8'h00, 32'h0,        1, 0,  8'h01, 8'h01, 32'h12345678, 1,  5'h00, 0,   0,   32'hbfc00380, 0};
        tbl[5] = '{"int_ex",    1, 5'h0c, 0, 32'hbfc00500, 0,   0,   8'h00, 32'h0,        1, 0,  8'h04, 8'h0c, 32'h0,        1,  5'h00, 0,   0,   32'hbfc00380, 0};
        tbl[6] = '{"adel",      1, 5'h04, 0, 32'hbfc00600, 0,   0,   8'h00, 32'h00000003, 0, 0,  8'h00, 8'h00, 32'h0,        1,  5'h04, 0,   0,   32'hbfc00380, 1};
        tbl[7] = '{"im_miss",   0, 5'h00, 0, 32'hbfc00700, 0,   1,   8'h2a, 32'h0,        1, 0,  8'h80, 8'h01, 32'h0,        0,  5'h00, 0,   1,   32'h0,        0};

        idle_inputs();
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_flush_req",  32'(flush_req),  32'h0);
        chk("rst_flush_pc",   flush_pc,        32'h0);
        chk("rst_ws_allowin", 32'(ws_allowin), 32'h1);
        chk("rst_wb_except",  32'(wb_except),  32'h0);
        chk("rst_eret_flush", 32'(eret_flush), 32'h0);
        chk("rst_mtc0_we",    32'(mtc0_we),    32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed table: load one instruction, commit it under the row's CP0 state, then run any flush.
        for (int i = 0; i < NT; i++) begin
            idle_inputs();
            ms_to_ws_valid = 1'b1; ms_ex = tbl[i].ex; ms_excode = tbl[i].code; ms_bd = tbl[i].bd;
            ms_pc = tbl[i].pc; ms_eret = tbl[i].eret; ms_mtc0 = tbl[i].mtc0;
            ms_c0_addr = tbl[i].addr; ms_badvaddr = tbl[i].bva;
            cycle();
            idle_inputs();
            c0_status_ie = tbl[i].ie; c0_status_exl = tbl[i].exl;
            c0_status_im = tbl[i].im; c0_cause_ip = tbl[i].ip; c0_epc = tbl[i].epc;
            #1;
            chk($sformatf("%s.wb_except", tbl[i].name), 32'(wb_except), 32'(tbl[i].x_exc));
            chk($sformatf("%s.eret_flush", tbl[i].name), 32'(eret_flush), 32'(tbl[i].x_eret));
            chk($sformatf("%s.mtc0_we", tbl[i].name), 32'(mtc0_we), 32'(tbl[i].x_mtc0));
            if (tbl[i].x_exc) begin
                chk($sformatf("%s.wb_excode", tbl[i].name), 32'(wb_excode), 32'(tbl[i].x_code));
                chk($sformatf("%s.wb_bd", tbl[i].name), 32'(wb_bd), 32'(tbl[i].bd));
                chk($sformatf("%s.wb_pc", tbl[i].name), wb_pc, tbl[i].pc);
            end
            if (tbl[i].x_mtc0) chk($sformatf("%s.c0_addr", tbl[i].name), 32'(c0_addr), 32'(tbl[i].addr));
`ifdef EXCEPT_COMMIT_BADVADDR_EN
            chk($sformatf("%s.bv_we", tbl[i].name), 32'(wb_badvaddr_we), 32'(tbl[i].x_bw));
            if (tbl[i].x_bw) chk($sformatf("%s.bv", tbl[i].name), wb_badvaddr, tbl[i].bva);
`endif
            cycle();
            idle_inputs();
            if (tbl[i].x_exc || tbl[i].x_eret) begin
                #1;
                chk($sformatf("%s.flush_req", tbl[i].name), 32'(flush_req), 32'h1);
                chk($sformatf("%s.flush_pc", tbl[i].name), flush_pc, tbl[i].x_fpc);
                cycle();
                fs_flush_ack = 1'b1;
                cycle();
                fs_flush_ack = 1'b0;
                #1;
                chk($sformatf("%s.flush_done", tbl[i].name), 32'(flush_req), 32'h0);
                cycle();
            end
        end

        // Ack while in RUN must be ignored; then flush drain with three discarded instructions.
        idle_inputs();
        fs_flush_ack = 1'b1;
        cycle();
        idle_inputs();
        ms_to_ws_valid = 1'b1; ms_ex = 1'b1; ms_excode = 5'h08; ms_pc = 32'hbfc00800;
        cycle();
        idle_inputs();
        cycle();
        for (int k = 0; k < 3; k++) begin
            ms_to_ws_valid = 1'b1; ms_ex = 1'b1; ms_excode = 5'h0a; ms_pc = 32'hbfc00900 + 32'(k * 4);
            fs_flush_ack = 1'(k == 2);
            #1;
            chk("drain.ws_allowin", 32'(ws_allowin), 32'h1);
            chk("drain.wb_except", 32'(wb_except), 32'h0);
            cycle();
        end
        idle_inputs();
        #1;
        chk("drain.after_except", 32'(wb_except), 32'h0);
        chk("drain.after_flush_req", 32'(flush_req), 32'h0);
        cycle();

        // Reset asserted in the middle of a flush drops flush_req without a clock edge.
        ms_to_ws_valid = 1'b1; ms_eret = 1'b1; c0_epc = 32'hbfc00a00;
        cycle();
        idle_inputs();
        c0_epc = 32'hbfc00a00;
        cycle();
        idle_inputs();
        cycle();
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst.flush_req", 32'(flush_req), 32'h0);
        chk("midrst.ws_allowin", 32'(ws_allowin), 32'h1);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        cycle();

        // Random run against the model.
        for (int n = 0; n < 3000; n++) begin
            int k;
            k = int'($urandom_range(0, 3));
            ms_to_ws_valid = 1'($urandom_range(0, 1));
            ms_ex          = 1'($urandom_range(0, 7) == 0);
            ms_excode      = 5'($urandom_range(0, 31));
            ms_bd          = 1'($urandom_range(0, 1));
            ms_pc          = $urandom;
            ms_eret        = 1'(k == 0);
            ms_mtc0        = 1'(k == 1);
            ms_c0_addr     = AW'($urandom);
            ms_badvaddr    = $urandom;
            c0_status_ie   = 1'($urandom_range(0, 1));
            c0_status_exl  = 1'($urandom_range(0, 3) == 0);
            c0_status_im   = 8'($urandom);
            c0_cause_ip    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
            c0_epc         = $urandom;
            fs_flush_ack   = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
